// File: rtl/crc_serial_engine_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC engine:
//   crc_state_e      - engine state encoding (IDLE / SHIFT_IN / SHIFT_OUT)
//   CRC*_POLY        - common generator polynomials, x^WIDTH term omitted
//   crc_cnt_width()  - width of the serial shift-out bit counter
// ---------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SHIFT_IN  = 2'b01,
    SHIFT_OUT = 2'b10
  } crc_state_e;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

  // The counter must be able to hold the value WIDTH.
  function automatic int unsigned crc_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/crc_serial_engine_if.sv
// ---------------------------------------------------------------------------
// crc_serial_engine_if
// Bundles the message input and CRC result signals of crc_serial_engine.
//   DATA     framer -> engine   message bit, qualified by ACTIVE
//   ACTIVE   framer -> engine   high for every bit of one message
//   CRC      engine -> encoder  finalised CRC (WIDTH bits)
//   CRC_RDY  engine -> encoder  CRC holds a finalised result
//   SER_OUT  engine -> encoder  serial CRC bit, meaningful while Valid=1
//   Valid    engine -> encoder  high for WIDTH cycles of serial output
//   BUSY     engine -> framer   engine cannot accept a new message
// Modports: master = framer/encoder side, slave = engine side.
// ---------------------------------------------------------------------------
interface crc_serial_engine_if #(
  parameter int unsigned WIDTH = 8
);

  logic             DATA;
  logic             ACTIVE;
  logic [WIDTH-1:0] CRC;
  logic             CRC_RDY;
  logic             SER_OUT;
  logic             Valid;
  logic             BUSY;

  modport master (
    output DATA,
    output ACTIVE,
    input  CRC,
    input  CRC_RDY,
    input  SER_OUT,
    input  Valid,
    input  BUSY
  );

  modport slave (
    input  DATA,
    input  ACTIVE,
    output CRC,
    output CRC_RDY,
    output SER_OUT,
    output Valid,
    output BUSY
  );

endinterface

// File: rtl/crc_serial_engine_bit_step.sv
// ---------------------------------------------------------------------------
// crc_bit_step
// Combinational single-bit LFSR update of a CRC register:
//   fb  = d ^ r[WIDTH-1]
//   r'  = (r << 1) ^ (fb ? POLY : 0)
// Ports:
//   r_i  current register value (WIDTH bits)
//   d_i  incoming message bit
//   r_o  updated register value (WIDTH bits)
// ---------------------------------------------------------------------------
module crc_bit_step #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h07)
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] r_o
);

  logic             fb;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    fb      = d_i ^ r_i[WIDTH-1];
    shifted = {r_i[WIDTH-2:0], 1'b0};
    r_o     = fb ? (shifted ^ POLY) : shifted;
  end

endmodule

// File: rtl/crc_serial_engine.sv
// ---------------------------------------------------------------------------
// crc_serial_engine
// Bit-serial CRC generator. Absorbs one message bit per clock while ACTIVE
// is high; when ACTIVE falls the CRC is finalised (XOR_OUT applied), held on
// CRC with CRC_RDY set, and shifted out on SER_OUT for WIDTH cycles framed
// by Valid. ACTIVE is ignored while the result is being shifted out.
// Ports:
//   CLK   clock, rising edge
//   RST   synchronous active-low reset
//   bus   crc_serial_engine_if.slave: DATA, ACTIVE in;
//         CRC, CRC_RDY, SER_OUT, Valid, BUSY out
// Parameters: WIDTH (4..32), POLY, SEED, XOR_OUT, SER_MSB_FIRST.
// ---------------------------------------------------------------------------
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] POLY          = WIDTH'(CRC8_POLY),
  parameter logic [WIDTH-1:0] SEED          = '0,
  parameter logic [WIDTH-1:0] XOR_OUT       = '0,
  parameter bit               SER_MSB_FIRST = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  crc_serial_engine_if.slave  bus
);

  localparam int unsigned CNT_W = crc_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  crc_state_e       state_q, state_d;
  logic [WIDTH-1:0] lfsr_q,  lfsr_d;
  logic [WIDTH-1:0] crc_q,   crc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             rdy_q,   rdy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [WIDTH-1:0] step_in;
  logic [WIDTH-1:0] step_out;

  // A single step instance serves both the first bit (from SEED) and the
  // following bits (from lfsr_q), so every message reseeds regardless of
  // what the previous message left in lfsr_q.
  assign step_in = (state_q == IDLE) ? SEED : lfsr_q;

  crc_bit_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .r_i (step_in),
    .d_i (bus.DATA),
    .r_o (step_out)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      crc_q   <= '0;
      shreg_q <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      crc_q   <= crc_d;
      shreg_q <= shreg_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    crc_d   = crc_q;
    shreg_d = shreg_q;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ACTIVE) begin
          lfsr_d  = step_out;
          rdy_d   = 1'b0;
          state_d = SHIFT_IN;
        end
      end

      SHIFT_IN: begin
        if (bus.ACTIVE) begin
          lfsr_d = step_out;
        end else begin
          crc_d   = lfsr_q ^ XOR_OUT;
          shreg_d = lfsr_q ^ XOR_OUT;
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT_OUT;
        end
      end

      SHIFT_OUT: begin
        // Zero fill drains the shift register, so SER_OUT rests at 0 in IDLE.
        shreg_d = SER_MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.CRC     = crc_q;
  assign bus.CRC_RDY = rdy_q;
  assign bus.SER_OUT = SER_MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.Valid   = (state_q == SHIFT_OUT);
  assign bus.BUSY    = (state_q != IDLE);

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
Parametrised bit-serial CRC generator, the successor to the fixed 8-bit CRC_BLOCK. It consumes one message bit per clock while ACTIVE is high. When ACTIVE falls, it finalises the CRC, presents it in parallel, and shifts it out serially with Valid framing. It sits between a serial framer and the line encoder. Width, polynomial, seed, output XOR and serial bit order are all configurable.

Parameters:
WIDTH, 8, CRC register width in bits (4..32)
POLY, 8'h07, generator polynomial with the implicit x^WIDTH term omitted
SEED, 8'h00, register value loaded at the start of each message
XOR_OUT, 8'h00, value XORed into the register at finalisation
SER_MSB_FIRST, 1, serial output order: 1 = CRC[WIDTH-1] first, 0 = CRC[0] first

Ports:
CLK  in  1  clock; all logic samples on the rising edge
RST  in  1  synchronous active-low reset
DATA  in  1  message bit; sampled only when ACTIVE=1
ACTIVE  in  1  message-bit qualifier; a high run of one or more cycles is one message
CRC  out  WIDTH  finalised CRC; frozen from finalisation until the next message starts
CRC_RDY  out  1  level: CRC holds a finalised result
SER_OUT  out  1  serial CRC bit; meaningful only while Valid=1
Valid  out  1  high for exactly WIDTH cycles while SER_OUT carries the CRC
BUSY  out  1  high in SHIFT_IN and SHIFT_OUT

Behaviour:
- Reset (RST=0 at a rising edge): state goes to IDLE; lfsr=SEED; CRC=0; CRC_RDY=0; SER_OUT=0; Valid=0; BUSY=0; bit counter=0. Reset mid-message or mid-shift-out aborts with no output.
- Step function, step(r,d):
  - fb = d ^ r[WIDTH-1]
  - r_next = (r << 1) truncated to WIDTH, XOR POLY if fb=1
- The block does not reorder message bits; the sender chooses the bit order.
- IDLE:
  - ACTIVE=1: lfsr <= step(SEED, DATA); CRC_RDY <= 0; go to SHIFT_IN.
  - ACTIVE=0: hold everything; CRC and CRC_RDY keep their last values.
- SHIFT_IN:
  - ACTIVE=1: lfsr <= step(lfsr, DATA).
  - ACTIVE=0: finalise. CRC <= lfsr ^ XOR_OUT; shift reg <= same value; CRC_RDY <= 1; count <= 0; go to SHIFT_OUT.
- SHIFT_OUT:
  - Valid=1 every cycle in this state.
  - SER_OUT is the current MSB of the shift reg (or LSB if SER_MSB_FIRST=0); the shift reg shifts once per cycle.
  - After WIDTH cycles, go to IDLE; Valid drops on the same edge.
  - The first serial bit appears the cycle after ACTIVE is sampled low, so latency from the last data bit to the first CRC bit is 1 cycle.
  - ACTIVE=1 in this state is ignored: the bits are dropped and no state changes. The sender must wait for BUSY=0.
- Back-to-back messages: ACTIVE may rise on the first cycle after Valid falls. That message restarts from SEED; it never continues from the previous lfsr.
- Zero-length message (ACTIVE never high): no output, CRC_RDY unchanged.
- CRC, SER_OUT and Valid are registered outputs with no combinational path from the inputs.

Decomposition:
- Shared package crc_pkg:
  - state enum IDLE / SHIFT_IN / SHIFT_OUT (2-bit encoding)
  - standard polynomial constants: CRC8_POLY=8'h07, CRC16_CCITT_POLY=16'h1021, CRC32_POLY=32'h04C11DB7
- Sub-module crc_bit_step: combinational single-bit LFSR update, parametrised by WIDTH and POLY.
- The bit counter width is clog2(WIDTH+1).

Test Plan:
- Default params; feed 0x01 MSB-first as 8 ACTIVE bits -> CRC=8'h07, CRC_RDY=1, Valid high for 8 cycles, SER_OUT=0,0,0,0,0,1,1,1.
- Default params; feed 0xFF -> CRC=8'hF3. Then feed ASCII "123456789" (72 bits, each byte MSB-first) starting the cycle after Valid falls -> CRC=8'hF4 and SER_OUT=1,1,1,1,0,1,0,0.
- WIDTH=16, POLY=16'h1021, SEED=16'hFFFF, XOR_OUT=0; feed "123456789" -> CRC=16'h29B1, Valid high for exactly 16 cycles.
- SER_MSB_FIRST=0 with default params, message 0x01 -> SER_OUT=1,1,1,0,0,0,0,0.
- Assert RST=0 for 1 cycle after 4 data bits -> all outputs return to reset values. A fresh 0x01 message then gives 8'h07, proving the reseed.
- Pulse ACTIVE=1 for 3 cycles during SHIFT_OUT -> serial stream and CRC unchanged, state returns to IDLE after WIDTH cycles.
